// File: rtl/sm_neuron_accum_if.sv
// ----------------------------------------------------------------------------
// sm_neuron_accum_if
//   Groups the control and product-stream signals of the neuron accumulator.
//   Signal names match the original flat port list of sm_neuron_accum.
//
//   master : frame controller / product source (drives i_*, observes o_*)
//   slave  : sm_neuron_accum (observes i_*, drives o_*)
//
//   i_start       begin a new frame (honoured in IDLE only)
//   i_bias        neuron bias, sign-magnitude
//   i_prod_valid  product word valid
//   i_prod        product word, sign-magnitude
//   i_prod_ovr    multiplier overflow flag, qualified by i_prod_valid
//   o_prod_ready  accumulator accepting products
//   o_busy        frame in progress (ACCUM or BIAS)
//   o_done        one-cycle pulse, result outputs newly valid
//   o_sum         saturated sum including bias, sign-magnitude
//   o_fire        sum strictly positive
//   o_ovr         overflow seen during the frame
// ----------------------------------------------------------------------------
interface sm_neuron_accum_if #(
    parameter int N = 16
);
    logic         i_start;
    logic [N-1:0] i_bias;
    logic         i_prod_valid;
    logic [N-1:0] i_prod;
    logic         i_prod_ovr;
    logic         o_prod_ready;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_sum;
    logic         o_fire;
    logic         o_ovr;

    modport master (
        output i_start, i_bias, i_prod_valid, i_prod, i_prod_ovr,
        input  o_prod_ready, o_busy, o_done, o_sum, o_fire, o_ovr
    );

    modport slave (
        input  i_start, i_bias, i_prod_valid, i_prod, i_prod_ovr,
        output o_prod_ready, o_busy, o_done, o_sum, o_fire, o_ovr
    );
endinterface

// File: rtl/sm_neuron_accum.sv
// ----------------------------------------------------------------------------
// sm_neuron_accum
//   Perceptron neuron accumulator. Consumes a frame of NUM_INPUTS
//   sign-magnitude Q-format products over a valid/ready stream, adds the
//   neuron bias, and presents a saturated N-bit sum plus a step-activation
//   fire flag for the digit-class compare stage.
//
//   i_clk  clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    sm_neuron_accum_if slave modport (start/bias/product stream in,
//          ready/busy/done/sum/fire/ovr out)
// ----------------------------------------------------------------------------
module sm_neuron_accum #(
    parameter int Q          = 12,
    parameter int N          = 16,
    parameter int NUM_INPUTS = 784,
    parameter int CNT_W      = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    sm_neuron_accum_if.slave   bus
);

    // Parameter legality; Q only has to leave room for an integer bit.
    if (Q > N - 2) begin : g_bad_q
        $error("sm_neuron_accum: Q must be <= N-2");
    end
    if (NUM_INPUTS < 1) begin : g_bad_num
        $error("sm_neuron_accum: NUM_INPUTS must be >= 1");
    end
    if ((64'd1 << CNT_W) < 64'(NUM_INPUTS)) begin : g_bad_cnt
        $error("sm_neuron_accum: CNT_W too narrow for NUM_INPUTS");
    end

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_BIAS,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           ovr_q, ovr_d;       // frame-internal overflow flag
    logic [N-1:0]   sum_q, sum_d;
    logic           fire_q, fire_d;
    logic           ovr_out_q, ovr_out_d;

    logic [N-1:0]   add_b;
    logic [N:0]     add_res;            // {saturated, sign, magnitude}

    // Sign-magnitude add with magnitude saturation. Returns {sat, result}.
    // A zero magnitude always comes back as +0, which also absorbs -0 inputs.
    function automatic logic [N:0] sm_add(input logic [N-1:0] a,
                                          input logic [N-1:0] b);
        logic [N-1:0] mag_sum;
        logic [N-2:0] mag;
        logic         sgn;
        logic         sat;
        mag_sum = '0;
        sat     = 1'b0;
        if (a[N-1] == b[N-1]) begin
            mag_sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
            sgn     = a[N-1];
            if (mag_sum[N-1]) begin
                mag = '1;
                sat = 1'b1;
            end else begin
                mag = mag_sum[N-2:0];
            end
        end else if (a[N-2:0] >= b[N-2:0]) begin
            mag = a[N-2:0] - b[N-2:0];
            sgn = a[N-1];
        end else begin
            mag = b[N-2:0] - a[N-2:0];
            sgn = b[N-1];
        end
        if (mag == '0) begin
            sgn = 1'b0;
        end
        return {sat, sgn, mag};
    endfunction

    // One shared adder: second operand is the product in ACCUM, bias otherwise.
    always_comb begin
        add_b   = (state_q == S_ACCUM) ? bus.i_prod : bus.i_bias;
        add_res = sm_add(acc_q, add_b);
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovr_d     = ovr_q;
        sum_d     = sum_q;
        fire_d    = fire_q;
        ovr_out_d = ovr_out_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovr_d   = 1'b0;
                end
            end
            S_ACCUM: begin
                if (bus.i_prod_valid) begin
                    acc_d = add_res[N-1:0];
                    cnt_d = cnt_q + CNT_W'(1);
                    ovr_d = ovr_q | bus.i_prod_ovr | add_res[N];
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_BIAS;
                    end
                end
            end
            S_BIAS: begin
                // Result registers load here so they are valid during DONE.
                acc_d     = add_res[N-1:0];
                ovr_d     = ovr_q | add_res[N];
                sum_d     = add_res[N-1:0];
                fire_d    = ~add_res[N-1] & (|add_res[N-2:0]);
                ovr_out_d = ovr_q | add_res[N];
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            sum_q     <= '0;
            fire_q    <= 1'b0;
            ovr_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            sum_q     <= sum_d;
            fire_q    <= fire_d;
            ovr_out_q <= ovr_out_d;
        end
    end

    assign bus.o_prod_ready = (state_q == S_ACCUM);
    assign bus.o_busy       = (state_q == S_ACCUM) || (state_q == S_BIAS);
    assign bus.o_done       = (state_q == S_DONE);
    assign bus.o_sum        = sum_q;
    assign bus.o_fire       = fire_q;
    assign bus.o_ovr        = ovr_out_q;

endmodule
